symbol_serializer: RTL and testbench

- Sits directly downstream of the mapper.
- Accepts one mapped word per valid/ready handshake: 7 lanes, each with rotation, polarity and flip bits.
- Emits the lanes one symbol per cycle, lane 0 first, toward the line driver.
- Holds one word in a holding buffer beside the word being sent, so back-to-back words stream with no idle cycle between them.

---
 rtl/symbol_serializer.sv | 141 ++++++++++++++
 tb/tb_symbol_serializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_serializer.sv
// rtl/symbol_serializer.sv - mapper word to per-lane symbol serializer with one-word holding buffer
module symbol_serializer #(
   parameter int NSYM  = 7,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NSYM-1:0]  tx_rotation,
   input  logic [NSYM-1:0]  tx_polarity,
   input  logic [NSYM-1:0]  tx_flip,
   output logic             sym_valid,
   input  logic             sym_ready,
   output logic             sym_rotation,
   output logic             sym_polarity,
   output logic             sym_flip,
   output logic [IDX_W-1:0] sym_index,
   output logic             sym_last,
   output logic             busy
);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [NSYM-1:0]  r_act_rot;
   logic [NSYM-1:0]  r_act_pol;
   logic [NSYM-1:0]  r_act_flip;
   logic [NSYM-1:0]  r_hold_rot;
   logic [NSYM-1:0]  r_hold_pol;
   logic [NSYM-1:0]  r_hold_flip;
   logic             r_hold_full;
   logic [IDX_W-1:0] r_idx;

   logic w_in_acc;
   logic w_out_acc;
   logic w_at_last;
   logic w_word_done;
   logic w_load_in;
   logic w_load_hold;
   logic w_to_hold;
   logic w_idx_inc;

   // in_ready comes from the hold flag only, so sym_ready never reaches it combinationally
   assign in_ready    = ~r_hold_full;
   assign sym_valid   = (r_state == S_SEND);
   assign w_in_acc    = in_valid & in_ready;
   assign w_out_acc   = sym_valid & sym_ready;
   assign w_at_last   = (r_idx == LAST_IDX);
   assign w_word_done = w_out_acc & w_at_last;

   always_comb begin
      w_state_nxt = r_state;
      w_load_in   = 1'b0;
      w_load_hold = 1'b0;
      w_to_hold   = 1'b0;
      w_idx_inc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_in_acc) begin
               w_load_in   = 1'b1;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (w_out_acc && !w_at_last) begin
               w_idx_inc = 1'b1;
            end
            if (w_word_done) begin
               if (r_hold_full) begin
                  w_load_hold = 1'b1;
               end else if (w_in_acc) begin
                  w_load_in = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            if (w_in_acc && !w_load_in) begin
               w_to_hold = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_act_rot   <= '0;
         r_act_pol   <= '0;
         r_act_flip  <= '0;
         r_hold_rot  <= '0;
         r_hold_pol  <= '0;
         r_hold_flip <= '0;
         r_hold_full <= 1'b0;
         r_idx       <= '0;
      end else begin
         if (w_load_in) begin
            r_act_rot  <= tx_rotation;
            r_act_pol  <= tx_polarity;
            r_act_flip <= tx_flip;
         end else if (w_load_hold) begin
            r_act_rot  <= r_hold_rot;
            r_act_pol  <= r_hold_pol;
            r_act_flip <= r_hold_flip;
         end

         if (w_load_in || w_load_hold || w_word_done) begin
            r_idx <= '0;
         end else if (w_idx_inc) begin
            r_idx <= r_idx + 1'b1;
         end

         if (w_to_hold) begin
            r_hold_rot  <= tx_rotation;
            r_hold_pol  <= tx_polarity;
            r_hold_flip <= tx_flip;
            r_hold_full <= 1'b1;
         end else if (w_load_hold) begin
            r_hold_full <= 1'b0;
         end
      end
   end

   assign sym_index    = r_idx;
   assign sym_rotation = sym_valid & r_act_rot[r_idx];
   assign sym_polarity = sym_valid & r_act_pol[r_idx];
   assign sym_flip     = sym_valid & r_act_flip[r_idx];
   assign sym_last     = sym_valid & w_at_last;
   assign busy         = sym_valid | r_hold_full;

endmodule

// File: tb/tb_symbol_serializer.sv
// tb/tb_symbol_serializer.sv - randomized bench for symbol_serializer against a word-queue model
module tb_symbol_serializer;

   localparam int NSYM  = 7;
   localparam int IDX_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [NSYM-1:0]  tx_rotation;
   logic [NSYM-1:0]  tx_polarity;
   logic [NSYM-1:0]  tx_flip;
   logic             sym_valid;
   logic             sym_ready;
   logic             sym_rotation;
   logic             sym_polarity;
   logic             sym_flip;
   logic [IDX_W-1:0] sym_index;
   logic             sym_last;
   logic             busy;

   symbol_serializer #(.NSYM(NSYM), .IDX_W(IDX_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .tx_rotation  (tx_rotation),
      .tx_polarity  (tx_polarity),
      .tx_flip      (tx_flip),
      .sym_valid    (sym_valid),
      .sym_ready    (sym_ready),
      .sym_rotation (sym_rotation),
      .sym_polarity (sym_polarity),
      .sym_flip     (sym_flip),
      .sym_index    (sym_index),
      .sym_last     (sym_last),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             rot;
      logic             pol;
      logic             flip;
      logic [IDX_W-1:0] idx;
      logic             last;
   } sym_t;

   // Expected symbol stream plus the number of words accepted but not yet fully sent
   sym_t q[$];
   int   inflight = 0;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   logic            t_rst    = 1'b1;
   logic            t_valid  = 1'b0;
   logic            t_sready = 1'b1;
   logic [NSYM-1:0] t_rot    = '0;
   logic [NSYM-1:0] t_pol    = '0;
   logic [NSYM-1:0] t_flip   = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic check_outputs();
      sym_t s;
      chk("in_ready", {31'd0, in_ready}, {31'd0, inflight < 2});
      chk("busy", {31'd0, busy}, {31'd0, inflight > 0});
      chk("sym_valid", {31'd0, sym_valid}, {31'd0, inflight > 0});
      if (inflight > 0) begin
         s = q[0];
         chk("sym_rotation", {31'd0, sym_rotation}, {31'd0, s.rot});
         chk("sym_polarity", {31'd0, sym_polarity}, {31'd0, s.pol});
         chk("sym_flip", {31'd0, sym_flip}, {31'd0, s.flip});
         chk("sym_index", {29'd0, sym_index}, {29'd0, s.idx});
         chk("sym_last", {31'd0, sym_last}, {31'd0, s.last});
      end else begin
         chk("idle_outputs", {25'd0, sym_rotation, sym_polarity, sym_flip, sym_last, sym_index}, 32'd0);
      end
   endtask

   // Drive one cycle at the falling edge, advance the model at the rising edge, check at the next falling edge
   task automatic step(output bit acc);
      bit   in_acc;
      bit   out_acc;
      sym_t s;
      rst         = t_rst;
      in_valid    = t_valid;
      tx_rotation = t_rot;
      tx_polarity = t_pol;
      tx_flip     = t_flip;
      sym_ready   = t_sready;
      in_acc  = !t_rst && t_valid && (inflight < 2);
      out_acc = !t_rst && (inflight > 0) && t_sready;
      acc = in_acc;
      @(posedge clk);
      if (t_rst) begin
         q.delete();
         inflight = 0;
      end else begin
         if (out_acc) begin
            s = q.pop_front();
            if (s.last) inflight--;
         end
         if (in_acc) begin
            for (int l = 0; l < NSYM; l++) begin
               s.rot  = t_rot[l];
               s.pol  = t_pol[l];
               s.flip = t_flip[l];
               s.idx  = IDX_W'(l);
               s.last = (l == NSYM - 1);
               q.push_back(s);
            end
            inflight++;
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(a);
   endtask

   task automatic send_word(input logic [NSYM-1:0] r, input logic [NSYM-1:0] p, input logic [NSYM-1:0] f);
      bit a;
      int tries;
      t_rot   = r;
      t_pol   = p;
      t_flip  = f;
      t_valid = 1'b1;
      a       = 1'b0;
      tries   = 0;
      while (!a && tries < 40) begin
         step(a);
         tries++;
      end
      if (!a) chk("accept_timeout", 32'd0, 32'd1);
      t_valid = 1'b0;
   endtask

   initial begin
      bit acc;
      int ready_level;

      @(negedge clk);
      t_rst = 1'b1;
      idle(2);
      t_rst = 1'b0;

      // Single word with a known bit pattern, full rate
      t_sready = 1'b1;
      send_word(7'h55, 7'h0F, 7'h01);
      idle(9);

      // Three words back to back; the third waits for the hold buffer to drain
      send_word(7'h12, 7'h34, 7'h56);
      send_word(7'h6A, 7'h15, 7'h2B);
      send_word(7'h7F, 7'h00, 7'h41);
      idle(25);

      // New word accepted on the same edge as lane 6 of the previous one
      send_word(7'h33, 7'h4C, 7'h70);
      idle(6);
      send_word(7'h0E, 7'h71, 7'h2A);
      idle(10);

      // Backpressure at lane 3
      send_word(7'h2D, 7'h5A, 7'h63);
      idle(3);
      t_sready = 1'b0;
      idle(5);
      t_sready = 1'b1;
      idle(8);

      // Reset at lane 4 with a word held
      send_word(7'h11, 7'h22, 7'h44);
      send_word(7'h7E, 7'h3C, 7'h18);
      idle(3);
      t_rst = 1'b1;
      idle(1);
      t_rst = 1'b0;
      idle(10);

      // All-zero word still produces seven symbols
      send_word(7'h00, 7'h00, 7'h00);
      idle(9);

      // Randomized traffic, backpressure and occasional reset
      for (int seg = 0; seg < 8; seg++) begin
         ready_level = (seg % 4) * 2 + 2;
         for (int c = 0; c < 500; c++) begin
            if (!t_valid && ($urandom % 4 != 0)) begin
               t_valid = 1'b1;
               if ($urandom % 8 == 0) begin
                  t_rot  = '0;
                  t_pol  = '0;
                  t_flip = '0;
               end else begin
                  t_rot  = NSYM'($urandom);
                  t_pol  = NSYM'($urandom);
                  t_flip = NSYM'($urandom);
               end
            end
            t_sready = (($urandom % 8) < ready_level);
            t_rst    = ($urandom % 300 == 0);
            step(acc);
            if (acc) t_valid = 1'b0;
         end
      end
      t_rst    = 1'b0;
      t_valid  = 1'b0;
      t_sready = 1'b1;
      idle(20);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
